// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the quadrature encoder emulator: phase encoding and defaults.
// The optional index/revolution logic in the top is enabled by defining QENC_INDEX_EN.
package quad_enc_pkg;

    localparam int unsigned EDGES_PER_REV_DEFAULT = 64;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2,
        S3
    } phase_e;

    // Returns {A, B} for a phase.
    function automatic logic [1:0] phase_ab(input phase_e p);
        logic [1:0] ab;
        unique case (p)
            S0:      ab = 2'b00;
            S1:      ab = 2'b10;
            S2:      ab = 2'b11;
            S3:      ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    function automatic phase_e next_phase(input phase_e p, input logic fwd);
        phase_e n;
        unique case (p)
            S0:      n = fwd ? S1 : S3;
            S1:      n = fwd ? S2 : S0;
            S2:      n = fwd ? S3 : S1;
            S3:      n = fwd ? S0 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qenc_tick_gen.sv
// Edge-rate divider: counts enabled clocks and emits a one-cycle tick every period_s clocks.
// period_s is re-sampled on a tick, on the rising edge of en, and whenever it is zero.
module qenc_tick_gen (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [7:0] period_i,
    output logic       tick_o
);

    logic       en_q, en_d;
    logic [7:0] period_s_q, period_s_d;
    logic [7:0] div_q, div_d;
    logic       en_rise;
    logic       halted;

    assign en_rise = en_i & ~en_q;
    assign halted  = (period_s_q == 8'd0);

    // The enabling edge only arms the divider, so the first edge lands P clocks later.
    assign tick_o = en_i && !en_rise && !halted && (div_q == period_s_q - 8'd1);

    always_comb begin
        en_d       = en_i;
        period_s_d = period_s_q;
        div_d      = div_q;
        if (en_rise || tick_o || halted) begin
            period_s_d = period_i;
        end
        if (!en_i || halted || en_rise || tick_o) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            period_s_q <= 8'd0;
            div_q      <= 8'd0;
        end else begin
            en_q       <= en_d;
            period_s_q <= period_s_d;
            div_q      <= div_d;
        end
    end

endmodule

// File: rtl/quad_enc_emulator.sv
// Quadrature encoder emulator: generates A/B, step, position and (with QENC_INDEX_EN) an
// once-per-revolution index pulse at a programmable edge rate.
module quad_enc_emulator
    import quad_enc_pkg::*;
#(
    parameter int unsigned EDGES_PER_REV = EDGES_PER_REV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  period,
    input  logic        dir,
    output logic        enca,
    output logic        encb,
    output logic        step,
    output logic        idx,
    output logic [15:0] pos
);

    localparam logic [7:0] RevMax = 8'(EDGES_PER_REV - 1);

    logic tick;

    qenc_tick_gen u_tick_gen (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .period_i(period),
        .tick_o  (tick)
    );

    phase_e      phase_q, phase_d;
    logic        enca_q, encb_q, step_q;
    logic [15:0] pos_q, pos_d;
    logic [1:0]  ab_d;

    always_comb begin
        phase_d = phase_q;
        pos_d   = pos_q;
        if (tick) begin
            phase_d = next_phase(phase_q, dir);
            pos_d   = dir ? pos_q + 16'd1 : pos_q - 16'd1;
        end
        ab_d = phase_ab(phase_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= S0;
            enca_q  <= 1'b0;
            encb_q  <= 1'b0;
            step_q  <= 1'b0;
            pos_q   <= 16'd0;
        end else begin
            phase_q <= phase_d;
            enca_q  <= ab_d[1];
            encb_q  <= ab_d[0];
            step_q  <= tick;
            pos_q   <= pos_d;
        end
    end

    assign enca = enca_q;
    assign encb = encb_q;
    assign step = step_q;
    assign pos  = pos_q;

`ifdef QENC_INDEX_EN
    logic [7:0] rev_q, rev_d;
    logic       idx_q, idx_d;

    // Index marks the 0 / EDGES_PER_REV-1 boundary, so crossing it either way pulses idx.
    always_comb begin
        rev_d = rev_q;
        idx_d = 1'b0;
        if (tick) begin
            if (dir) begin
                if (rev_q == RevMax) begin
                    rev_d = 8'd0;
                    idx_d = 1'b1;
                end else begin
                    rev_d = rev_q + 8'd1;
                end
            end else begin
                if (rev_q == 8'd0) begin
                    rev_d = RevMax;
                    idx_d = 1'b1;
                end else begin
                    rev_d = rev_q - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_q <= 8'd0;
            idx_q <= 1'b0;
        end else begin
            rev_q <= rev_d;
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
`else
    logic [7:0] unused_rev_max;
    assign unused_rev_max = RevMax;
    assign idx            = 1'b0;
`endif

endmodule

// File: tb/tb_quad_enc_emulator.sv
// Self-checking bench for quad_enc_emulator: directed vector table, corner sequences and
// randomized stimulus against a time-based reference model.
module tb_quad_enc_emulator;

    localparam int EPR = 64;
`ifdef QENC_INDEX_EN
    localparam bit IDX_ON = 1'b1;
`else
    localparam bit IDX_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  period = 8'd0;
    logic        dir = 1'b1;
    logic        enca, encb, step, idx;
    logic [15:0] pos;

    quad_enc_emulator #(.EDGES_PER_REV(EPR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .period(period),
        .dir   (dir),
        .enca  (enca),
        .encb  (encb),
        .step  (step),
        .idx   (idx),
        .pos   (pos)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: countdown to the next edge; A/B follow the Gray code of pos mod 4.
    int m_pos, m_rev, m_per, m_rem;
    bit m_prev_en, m_step, m_idx;

    typedef struct {
        bit        en;
        bit [7:0]  per;
        bit        dir;
        int        cycles;
        bit [1:0]  ab;
        bit [15:0] pos;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit e, bit [7:0] p, bit d, int c, bit [1:0] ab, bit [15:0] ps);
        vec_t v;
        v.en = e; v.per = p; v.dir = d; v.cycles = c; v.ab = ab; v.pos = ps;
        tbl.push_back(v);
    endfunction

    function automatic bit [1:0] gray_ab(int p);
        bit [1:0] g[4];
        g[0] = 2'b00; g[1] = 2'b10; g[2] = 2'b11; g[3] = 2'b01;
        return g[p % 4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_rev = 0; m_per = 0; m_rem = 0;
        m_prev_en = 1'b0; m_step = 1'b0; m_idx = 1'b0;
    endtask

    task automatic model_edge();
        m_step = 1'b0;
        m_idx  = 1'b0;
        if (en) begin
            if (!m_prev_en || m_per == 0) begin
                m_per = period;
                m_rem = period;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_step = 1'b1;
                    if (dir) begin
                        m_pos = (m_pos + 1) % 65536;
                        m_rev = (m_rev + 1) % EPR;
                        if (m_rev == 0) m_idx = IDX_ON;
                    end else begin
                        m_pos = (m_pos + 65535) % 65536;
                        if (m_rev == 0) m_idx = IDX_ON;
                        m_rev = (m_rev + EPR - 1) % EPR;
                    end
                    m_per = period;
                    m_rem = period;
                end
            end
        end
        m_prev_en = en;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", {12'd0, enca, encb, step, idx, pos},
              {12'd0, gray_ab(m_pos), m_step, m_idx, m_pos[15:0]});
    endtask

    // Called at posedge+1: asserts reset between edges and checks outputs clear at once.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, {12'd0, enca, encb, step, idx, pos}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit last_idx;
        bit reached;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {12'd0, enca, encb, step, idx, pos}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add(1, 4, 1, 4, 2'b00, 16'd0);
        add(1, 4, 1, 1, 2'b10, 16'd1);
        add(1, 4, 1, 8, 2'b01, 16'd3);
        add(1, 4, 0, 4, 2'b11, 16'd2);
        add(1, 4, 0, 4, 2'b10, 16'd1);
        add(1, 4, 1, 12, 2'b00, 16'd4);
        add(1, 4, 1, 2, 2'b00, 16'd4);
        add(1, 10, 1, 1, 2'b00, 16'd4);
        add(1, 10, 1, 1, 2'b10, 16'd5);
        add(1, 10, 1, 9, 2'b10, 16'd5);
        add(1, 10, 1, 1, 2'b11, 16'd6);
        add(1, 10, 1, 5, 2'b11, 16'd6);
        add(0, 10, 1, 20, 2'b11, 16'd6);
        add(1, 10, 1, 10, 2'b11, 16'd6);
        add(1, 10, 1, 1, 2'b01, 16'd7);
        add(1, 1, 1, 10, 2'b00, 16'd8);
        add(1, 1, 1, 4, 2'b00, 16'd12);
        add(1, 0, 1, 1, 2'b10, 16'd13);
        add(1, 0, 1, 5, 2'b10, 16'd13);
        add(1, 3, 1, 3, 2'b10, 16'd13);
        add(1, 3, 1, 1, 2'b11, 16'd14);

        foreach (tbl[i]) begin
            en = tbl[i].en;
            period = tbl[i].per;
            dir = tbl[i].dir;
            repeat (tbl[i].cycles) run_cycle();
            check($sformatf("vec%0d", i), {14'd0, enca, encb, pos}, {14'd0, tbl[i].ab, tbl[i].pos});
        end

        // Run to pos 0x0012, then reset between clock edges.
        en = 1'b1; period = 8'd1; dir = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            run_cycle();
            if (m_pos == 18) reached = 1'b1;
        end
        check("reach_0x12", {16'd0, pos}, 32'h0000_0012);
        async_reset("async_reset");

        // One reverse edge from zero wraps pos and the revolution counter.
        en = 1'b1; period = 8'd1; dir = 1'b0;
        repeat (2) run_cycle();
        check("rev_from_zero", {15'd0, idx, pos}, {15'd0, IDX_ON, 16'hFFFF});
        dir = 1'b1;
        run_cycle();
        cnt = 0;
        last_idx = 1'b0;
        for (int k = 0; k < EPR; k++) begin
            run_cycle();
            cnt += int'(idx);
            last_idx = idx;
        end
        check("idx_count_64", cnt, IDX_ON ? 32'd1 : 32'd0);
        check("idx_on_edge64", {31'd0, last_idx}, {31'd0, IDX_ON});
        check("pos_after_64", {16'd0, pos}, 32'd64);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                en = ($urandom_range(0, 9) != 0);
                period = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
                dir = 1'($urandom_range(0, 1));
            end
            run_cycle();
            if ($urandom_range(0, 399) == 0) async_reset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
